// File: rtl/mod20_pkg.sv
// Shared constants, state and mode encodings for the mod-20 run-control sequencer.
package mod20_pkg;

    localparam int MOD = 20;
    localparam int W   = 5;

    localparam logic [W-1:0] MAXV    = W'(MOD - 1);
    localparam logic [W-1:0] MAXV_M1 = W'(MOD - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_PING = 2'd2,
        MODE_FREE = 2'd3
    } mode_e;

    // Targets beyond the count range can never be reached, so pin them to the top value.
    function automatic logic [W-1:0] clamp_target(input logic [W-1:0] t);
        return (t > MAXV) ? MAXV : t;
    endfunction

endpackage

// File: rtl/mod20_count_en.sv
// Mod-20 up/down counter datapath with synchronous load and a terminal-count flag.
module mod20_count_en
    import mod20_pkg::*;
(
    input  logic         clk,
    input  logic         Reset_n,
    input  logic         en_i,
    input  logic         dir_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] count_o,
    output logic         term_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            if (dir_i) begin
                count_d = (count_q == '0) ? MAXV : count_q - 1'b1;
            end else begin
                count_d = (count_q == MAXV) ? '0 : count_q + 1'b1;
            end
        end
    end

    // Falling-edge update keeps this block in step with the existing counter timing.
    always_ff @(negedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = dir_i ? (count_q == '0) : (count_q == MAXV);

endmodule

// File: rtl/mod20_seq_ctrl.sv
// Run-control sequencer: start/stop/pause FSM driving the mod-20 counter in one of four modes.
module mod20_seq_ctrl
    import mod20_pkg::*;
(
    input  logic         clk,
    input  logic         Reset_n,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic [1:0]   mode,
    input  logic [W-1:0] target,
    output logic [W-1:0] count,
    output logic         dir,
    output logic         busy,
    output logic         done,
    output logic         wrap,
    output logic [1:0]   dbg_state
);

    seq_state_e   state_q, state_d;
    mode_e        mode_q, mode_d;
    logic [W-1:0] target_q, target_d;
    logic         dir_q, dir_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         wrap_q, wrap_d;

    logic         cnt_en;
    logic         cnt_load;
    logic [W-1:0] cnt_load_val;
    logic         cnt_term;

    mod20_count_en u_count (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .en_i       (cnt_en),
        .dir_i      (dir_q),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .count_o    (count),
        .term_o     (cnt_term)
    );

    // Priority per edge: stop, then start (IDLE only), then pause, then a count step.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        target_d     = target_q;
        dir_d        = dir_q;
        done_d       = 1'b0;
        wrap_d       = 1'b0;
        cnt_en       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;

        if (stop) begin
            state_d  = ST_IDLE;
            dir_d    = 1'b0;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d   = mode_e'(mode);
                        target_d = clamp_target(target);
                        state_d  = ST_RUN;
                        cnt_load = 1'b1;
                        if (mode_e'(mode) == MODE_DOWN) begin
                            cnt_load_val = MAXV;
                            dir_d        = 1'b1;
                        end else begin
                            dir_d = 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        case (mode_q)
                            MODE_UP, MODE_DOWN: begin
                                if (count == target_q) begin
                                    done_d  = 1'b1;
                                    state_d = ST_DONE;
                                end else begin
                                    cnt_en = 1'b1;
                                end
                            end
                            MODE_PING: begin
                                // Turn around at either end by loading the neighbour value directly.
                                if (cnt_term) begin
                                    wrap_d       = 1'b1;
                                    dir_d        = ~dir_q;
                                    cnt_load     = 1'b1;
                                    cnt_load_val = dir_q ? W'(1) : MAXV_M1;
                                end else begin
                                    cnt_en = 1'b1;
                                end
                            end
                            default: begin
                                cnt_en = 1'b1;
                                wrap_d = cnt_term;
                            end
                        endcase
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    always_ff @(negedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_UP;
            target_q <= '0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    assign dir       = dir_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wrap      = wrap_q;
    assign dbg_state = state_q;

endmodule
